// File: rtl/mmio_pkg.sv
// Shared constants and address decode for the data-side memory/MMIO block.
package mmio_pkg;

  localparam logic [15:0] IO_BASE_HI = 16'hFFFF;

  localparam logic [7:0] OFF_GPIO   = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    SelRam,
    SelGpio,
    SelTx,
    SelStatus,
    SelCycles,
    SelNone
  } sel_e;

  // Only aluout[7:0] selects an I/O register, so aluout[15:8] aliases the window.
  function automatic sel_e decode(logic [31:0] addr);
    sel_e sel;
    if (addr[31:16] != IO_BASE_HI) begin
      sel = SelRam;
    end else begin
      case (addr[7:0])
        OFF_GPIO:   sel = SelGpio;
        OFF_TXDATA: sel = SelTx;
        OFF_STATUS: sel = SelStatus;
        OFF_CYCLES: sel = SelCycles;
        default:    sel = SelNone;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push while full is still accepted when a pop frees
// the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  // Head reads as zero when empty so the consumer never sees stale bytes.
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; empty gating on dout hides old contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped GPIO, TX byte FIFO, status and cycle counter
// behind the single-cycle core's load/store port. Loads are combinational.
module dmem_mmio
  import mmio_pkg::*;
#(
  parameter int unsigned DMEM_WORDS   = 64,
  parameter int unsigned TXFIFO_DEPTH = 4,
  parameter int unsigned GPIO_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       aluout,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);
  localparam int unsigned CW = $clog2(TXFIFO_DEPTH) + 1;

  sel_e              sel;
  logic [AW-1:0]     widx;
  logic [31:0]       ram [DMEM_WORDS];
  logic [GPIO_W-1:0] gpio_q;
  logic              ovf_q;
  logic [31:0]       cycles_q;
  logic              push_req, pop, rejected;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [31:0]       status_word;
  logic              unused_addr_bits;

  assign sel  = decode(aluout);
  assign widx = aluout[AW+1:2];
  // Byte-lane and alias bits of the address carry no meaning here.
  assign unused_addr_bits = ^{aluout[15:8], aluout[1:0]};

  // Word RAM, written on stores outside the I/O window; no reset.
  always_ff @(posedge clk) begin
    if (memwrite && sel == SelRam) ram[widx] <= writedata;
  end

  assign push_req = memwrite & (sel == SelTx);
  assign pop      = tx_valid & tx_ready;
  assign rejected = push_req & fifo_full & ~pop;
  assign tx_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TXFIFO_DEPTH)
  ) u_txfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (writedata[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // GPIO, sticky overflow and cycle counter; a counter store beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q   <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      if (memwrite && sel == SelGpio) gpio_q <= writedata[GPIO_W-1:0];
      if (rejected) begin
        ovf_q <= 1'b1;
      end else if (memwrite && sel == SelStatus && writedata[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (memwrite && sel == SelCycles) cycles_q <= writedata;
      else                              cycles_q <= cycles_q + 32'd1;
    end
  end

  assign gpio_out = gpio_q;

  // Load mux over pre-edge state.
  always_comb begin
    status_word                        = '0;
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_OVF]                = ovf_q;
    status_word[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    case (sel)
      SelRam:    readdata = ram[widx];
      SelGpio:   readdata = 32'(gpio_q);
      SelStatus: readdata = status_word;
      SelCycles: readdata = cycles_q;
      default:   readdata = '0;
    endcase
  end

endmodule
